// File: rtl/dom_and_stage.sv
// Pipelined DOM-indep masked AND gadget of order D: a resharing register layer, then a compression register layer.
// Optional feature macro SHARE_CLEAR_EN: a stage that drains writes its data registers to zero.
module dom_and_stage #(
  parameter  int unsigned D  = 1,
  localparam int unsigned N  = D + 1,
  localparam int unsigned NR = D * (D + 1) / 2,
  localparam int unsigned RW = (NR == 0) ? 1 : NR
) (
  input  logic          C,
  input  logic          R,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_sh,
  input  logic [N-1:0]  b_sh,
  input  logic [RW-1:0] rnd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  q_sh
);

  logic           s1_valid;
  logic           s2_valid;
  logic           s2_adv;
  logic           load1;
  logic           load2;
  logic [N*N-1:0] term_d;
  logic [N*N-1:0] term_q;
  logic [N-1:0]   q_d;

  // Handshake: each stage advances when the one after it is empty or draining.
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign load1     = in_valid && in_ready;
  assign load2     = s1_valid && s2_adv;
  assign out_valid = s2_valid;

  // Resharing terms; r_ij and r_ji share one rnd bit, packed row-major over i<j.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (i == j) begin : g_diag
        assign term_d[i*N+j] = a_sh[i] & b_sh[j];
      end else begin : g_cross
        localparam int unsigned LO = (i < j) ? i : j;
        localparam int unsigned HI = (i < j) ? j : i;
        localparam int unsigned K  = LO * (2 * D - LO + 1) / 2 + HI - LO - 1;
        assign term_d[i*N+j] = (a_sh[i] & b_sh[j]) ^ rnd[K];
      end
    end
  end

  // Compression reads only registered terms, so no input reaches q_sh combinationally.
  for (genvar i = 0; i < N; i++) begin : g_comp
    assign q_d[i] = ^term_q[i*N +: N];
  end

  always_ff @(posedge C) begin
    if (!R) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      term_q   <= '0;
      q_sh     <= '0;
    end else begin
      s1_valid <= load1 || (s1_valid && !s2_adv);
      s2_valid <= load2 || (s2_valid && !out_ready);

      if (load1) term_q <= term_d;
`ifdef SHARE_CLEAR_EN
      else if (s2_adv) term_q <= '0;
`endif

      if (load2) q_sh <= q_d;
`ifdef SHARE_CLEAR_EN
      else if (out_ready) q_sh <= '0;
`endif
    end
  end

endmodule
